// File: rtl/glitch_sweep_if.sv
// Control/status bundle between the glitch sweep sequencer (slave) and whatever drives it (master).
interface glitch_sweep_if;
    logic        start;
    logic        abort;
    logic        trigger;
    logic        success;
    logic [31:0] delay;
    logic        set_delay;
    logic        trigger_arm;
    logic        success_arm;
    logic        target_reset;
    logic        busy;
    logic        found;
    logic [31:0] found_delay;
    logic [31:0] attempt_count;

    modport master (
        output start, abort, trigger, success,
        input  delay, set_delay, trigger_arm, success_arm, target_reset,
               busy, found, found_delay, attempt_count
    );

    modport slave (
        input  start, abort, trigger, success,
        output delay, set_delay, trigger_arm, success_arm, target_reset,
               busy, found, found_delay, attempt_count
    );
endinterface

// File: rtl/glitch_sweep.sv
// Clock-glitch delay sweep sequencer: load delay, power-cycle target, arm trigger, await success.
// Optional GLITCH_SWEEP_ATTEMPTS_EN repeats each delay value ATTEMPTS times before advancing.
module glitch_sweep #(
    parameter logic [31:0] DELAY_START  = 32'd0,
    parameter logic [31:0] DELAY_STEP   = 32'd1,
    parameter logic [31:0] DELAY_END    = 32'd1000,
    parameter int unsigned RESET_WAIT   = 4800200,
    parameter int unsigned TRIG_TIMEOUT = 4800000,
    parameter int unsigned RES_TIMEOUT  = 48000,
    parameter int unsigned ATTEMPTS     = 4
) (
    input  logic          clk,
    input  logic          rst,
    glitch_sweep_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, RESET, ARM, WAIT_RES, NEXT, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cur_q, cur_d;
    logic [31:0] attempt_count_q, attempt_count_d;
    logic        found_q, found_d;
    logic [31:0] found_delay_q, found_delay_d;

    logic [31:0] cnt_inc;
    logic [32:0] next_cur;
    logic        sweep_start;
    logic        last_try;

    assign cnt_inc     = cnt_q + 32'd1;
    // 33-bit sum so a carry out reads as "past the end" instead of wrapping to a small delay
    assign next_cur    = {1'b0, cur_q} + {1'b0, DELAY_STEP};
    assign sweep_start = !bus.abort && bus.start && (state_q == IDLE || state_q == DONE);

`ifdef GLITCH_SWEEP_ATTEMPTS_EN
    logic [31:0] try_q, try_d;

    assign last_try = (try_q + 32'd1 >= ATTEMPTS);

    always_comb begin
        try_d = try_q;
        if (sweep_start) begin
            try_d = '0;
        end else if (state_q == NEXT && !bus.abort) begin
            try_d = last_try ? '0 : try_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            try_q <= '0;
        end else begin
            try_q <= try_d;
        end
    end
`else
    logic [31:0] unused_attempts;
    assign unused_attempts = ATTEMPTS;
    assign last_try        = 1'b1;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cur_d           = cur_q;
        attempt_count_d = attempt_count_q;
        found_d         = found_q;
        found_delay_d   = found_delay_q;

        if (bus.abort) begin
            state_d = IDLE;
        end else if (sweep_start) begin
            cur_d           = DELAY_START;
            attempt_count_d = '0;
            found_d         = 1'b0;
            state_d         = LOAD;
        end else begin
            case (state_q)
                LOAD: begin
                    cnt_d   = '0;
                    state_d = RESET;
                end
                RESET: begin
                    if (cnt_q == RESET_WAIT) begin
                        cnt_d   = '0;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ARM: begin
                    if (bus.trigger) begin
                        cnt_d   = '0;
                        state_d = WAIT_RES;
                    end else if (cnt_inc >= TRIG_TIMEOUT) begin
                        state_d = NEXT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WAIT_RES: begin
                    if (bus.success) begin
                        found_d       = 1'b1;
                        found_delay_d = cur_q;
                        state_d       = DONE;
                    end else if (cnt_inc >= RES_TIMEOUT) begin
                        state_d = NEXT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                NEXT: begin
                    attempt_count_d = attempt_count_q + 32'd1;
                    if (!last_try) begin
                        state_d = LOAD;
                    end else if (next_cur > {1'b0, DELAY_END}) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = next_cur[31:0];
                        state_d = LOAD;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            cur_q           <= DELAY_START;
            attempt_count_q <= '0;
            found_q         <= 1'b0;
            found_delay_q   <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cur_q           <= cur_d;
            attempt_count_q <= attempt_count_d;
            found_q         <= found_d;
            found_delay_q   <= found_delay_d;
        end
    end

    // Arm levels are gated by abort so the edge detectors are released in the abort cycle itself
    assign bus.delay         = cur_q;
    assign bus.set_delay     = (state_q == LOAD);
    assign bus.target_reset  = (state_q == RESET) && (cnt_q == '0);
    assign bus.trigger_arm   = (state_q == ARM) && !bus.abort;
    assign bus.success_arm   = (state_q == WAIT_RES) && !bus.abort;
    assign bus.busy          = (state_q != IDLE) && (state_q != DONE);
    assign bus.found         = found_q;
    assign bus.found_delay   = found_delay_q;
    assign bus.attempt_count = attempt_count_q;

endmodule

// File: tb/tb_glitch_sweep.sv
// Self-checking bench for glitch_sweep: randomized trigger/success timing against a sweep-level model.
`timescale 1ns/1ps
module tb_glitch_sweep;
    localparam logic [31:0] DSTART = 32'd0;
    localparam logic [31:0] DSTEP  = 32'd2;
    localparam logic [31:0] DEND   = 32'd6;
    localparam int unsigned RW = 5;
    localparam int unsigned TT = 10;
    localparam int unsigned RT = 8;
    localparam logic [31:0] WSTART = 32'hFFFF_FFFE;
    localparam logic [31:0] WSTEP  = 32'd4;
    localparam logic [31:0] WEND   = 32'hFFFF_FFFF;
`ifdef GLITCH_SWEEP_ATTEMPTS_EN
    localparam int unsigned TRIES  = 3;
    localparam int unsigned WTRIES = 2;
`else
    localparam int unsigned TRIES  = 1;
    localparam int unsigned WTRIES = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    glitch_sweep_if bus();
    glitch_sweep_if wbus();

    glitch_sweep #(.DELAY_START(DSTART), .DELAY_STEP(DSTEP), .DELAY_END(DEND), .RESET_WAIT(RW),
                   .TRIG_TIMEOUT(TT), .RES_TIMEOUT(RT), .ATTEMPTS(TRIES))
        u_dut (.clk(clk), .rst(rst_n), .bus(bus));

    glitch_sweep #(.DELAY_START(WSTART), .DELAY_STEP(WSTEP), .DELAY_END(WEND), .RESET_WAIT(2),
                   .TRIG_TIMEOUT(3), .RES_TIMEOUT(3), .ATTEMPTS(WTRIES))
        u_wrap (.clk(clk), .rst(rst_n), .bus(wbus));

    int n_checks = 0;
    int n_fail = 0;

    int trig_plan[64];
    int succ_plan[64];
    bit stray_en = 1'b0;

    logic [31:0] exp_vals[$];
    int exp_arm[$], exp_sarm[$];
    bit exp_found;
    logic [31:0] exp_fd;
    int exp_cnt;

    int cyc = 0;
    logic [31:0] sd_vals[$];
    int sd_cyc[$], tr_cyc[$], arm_rise[$], arm_len[$], sarm_len[$];
    int arm_run = 0, sarm_run = 0;
    int w_sd_cnt = 0, w_bad = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.set_delay) begin
            sd_vals.push_back(bus.delay);
            sd_cyc.push_back(cyc);
        end
        if (bus.target_reset) tr_cyc.push_back(cyc);
        if (bus.trigger_arm) begin
            if (arm_run == 0) arm_rise.push_back(cyc);
            arm_run++;
        end else if (arm_run != 0) begin
            arm_len.push_back(arm_run);
            arm_run = 0;
        end
        if (bus.success_arm) sarm_run++;
        else if (sarm_run != 0) begin
            sarm_len.push_back(sarm_run);
            sarm_run = 0;
        end
        if (wbus.set_delay) w_sd_cnt++;
        if (wbus.busy && wbus.delay !== WSTART) w_bad++;
    end

    // Target emulation: answers each attempt according to the plan for that attempt index
    int ta_cnt = 0, sa_cnt = 0, rk;
    always @(negedge clk) begin
        bus.trigger = 1'b0;
        bus.success = 1'b0;
        rk = (sd_vals.size() > 0) ? sd_vals.size() - 1 : 0;
        if (bus.trigger_arm) begin
            ta_cnt++;
            if (ta_cnt == trig_plan[rk]) bus.trigger = 1'b1;
            if (stray_en && ta_cnt == 1) bus.success = 1'b1;
        end else ta_cnt = 0;
        if (bus.success_arm) begin
            sa_cnt++;
            if (sa_cnt == succ_plan[rk]) bus.success = 1'b1;
            if (stray_en && sa_cnt == 1) bus.trigger = 1'b1;
        end else sa_cnt = 0;
    end

    task automatic model(input longint s, input longint st, input longint e,
                         input int tt, input int rt, input int unsigned tries);
        longint cur = s;
        int k = 0;
        bit stop = 1'b0;
        exp_vals.delete(); exp_arm.delete(); exp_sarm.delete();
        exp_found = 1'b0; exp_fd = '0; exp_cnt = 0;
        while (!stop) begin
            for (int unsigned t = 0; t < tries && !stop; t++) begin
                bit trg, suc;
                trg = trig_plan[k] >= 1 && trig_plan[k] <= tt;
                suc = trg && succ_plan[k] >= 1 && succ_plan[k] <= rt;
                exp_vals.push_back(cur[31:0]);
                exp_arm.push_back(trg ? trig_plan[k] : tt);
                if (trg) exp_sarm.push_back(suc ? succ_plan[k] : rt);
                k++;
                if (suc) begin
                    exp_found = 1'b1;
                    exp_fd = cur[31:0];
                    stop = 1'b1;
                end else exp_cnt++;
            end
            if (!stop) begin
                if (cur + st > e) stop = 1'b1;
                else cur += st;
            end
        end
    endtask

    task automatic run_sweep(input string name, input bit poke);
        bit poked = 1'b0;
        int n = 0;
        model(DSTART, DSTEP, DEND, TT, RT, TRIES);
        sd_vals.delete(); sd_cyc.delete(); tr_cyc.delete();
        arm_rise.delete(); arm_len.delete(); sarm_len.delete();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        n_checks++;
        if (bus.set_delay !== 1'b1 || bus.delay !== DSTART) begin
            n_fail++;
            $display("FAIL %s start_latency: set_delay=%b delay=%0d expected set_delay=1 delay=%0d",
                     name, bus.set_delay, bus.delay, DSTART);
        end
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
            if (poke && !poked && bus.trigger_arm) begin
                bus.start = 1'b1;
                poked = 1'b1;
            end else bus.start = 1'b0;
        end
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s sweep_timeout: busy=%b after %0d cycles, expected 0", name, bus.busy, n);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (sd_vals.size() != exp_vals.size()) begin
            n_fail++;
            $display("FAIL %s n_set_delay: got %0d expected %0d", name, sd_vals.size(), exp_vals.size());
        end
        for (int i = 0; i < sd_vals.size() && i < exp_vals.size(); i++) begin
            n_checks++;
            if (sd_vals[i] !== exp_vals[i]) begin
                n_fail++;
                $display("FAIL %s delay[%0d]: got %0d expected %0d", name, i, sd_vals[i], exp_vals[i]);
            end
        end
        n_checks++;
        if (tr_cyc.size() != exp_vals.size() || arm_rise.size() != exp_vals.size()) begin
            n_fail++;
            $display("FAIL %s n_target_reset/n_arm: got %0d/%0d expected %0d",
                     name, tr_cyc.size(), arm_rise.size(), exp_vals.size());
        end
        for (int i = 0; i < tr_cyc.size() && i < sd_cyc.size(); i++) begin
            n_checks++;
            if (tr_cyc[i] != sd_cyc[i] + 1) begin
                n_fail++;
                $display("FAIL %s target_reset_cycle[%0d]: got %0d expected %0d", name, i, tr_cyc[i], sd_cyc[i] + 1);
            end
        end
        for (int i = 0; i < arm_rise.size() && i < tr_cyc.size(); i++) begin
            n_checks++;
            if (arm_rise[i] != tr_cyc[i] + int'(RW) + 1) begin
                n_fail++;
                $display("FAIL %s arm_rise[%0d]: got %0d expected %0d", name, i, arm_rise[i], tr_cyc[i] + int'(RW) + 1);
            end
        end
        n_checks++;
        if (arm_len.size() != exp_arm.size() || sarm_len.size() != exp_sarm.size()) begin
            n_fail++;
            $display("FAIL %s n_arm_windows: got %0d/%0d expected %0d/%0d",
                     name, arm_len.size(), sarm_len.size(), exp_arm.size(), exp_sarm.size());
        end
        for (int i = 0; i < arm_len.size() && i < exp_arm.size(); i++) begin
            n_checks++;
            if (arm_len[i] != exp_arm[i]) begin
                n_fail++;
                $display("FAIL %s trigger_arm_len[%0d]: got %0d expected %0d", name, i, arm_len[i], exp_arm[i]);
            end
        end
        for (int i = 0; i < sarm_len.size() && i < exp_sarm.size(); i++) begin
            n_checks++;
            if (sarm_len[i] != exp_sarm[i]) begin
                n_fail++;
                $display("FAIL %s success_arm_len[%0d]: got %0d expected %0d", name, i, sarm_len[i], exp_sarm[i]);
            end
        end
        n_checks++;
        if (bus.found !== exp_found || bus.attempt_count !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s result: found=%b attempt_count=%0d expected found=%b attempt_count=%0d",
                     name, bus.found, bus.attempt_count, exp_found, exp_cnt);
        end
        if (exp_found) begin
            n_checks++;
            if (bus.found_delay !== exp_fd) begin
                n_fail++;
                $display("FAIL %s found_delay: got %0d expected %0d", name, bus.found_delay, exp_fd);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.delay !== DSTART) begin
            n_fail++;
            $display("FAIL reset_delay: got %0d expected %0d", bus.delay, DSTART);
        end
        n_checks++;
        if ({bus.set_delay, bus.target_reset, bus.trigger_arm, bus.success_arm, bus.busy, bus.found} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {bus.set_delay, bus.target_reset, bus.trigger_arm, bus.success_arm, bus.busy, bus.found});
        end
        n_checks++;
        if (bus.found_delay !== 32'd0 || bus.attempt_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counts: found_delay=%0d attempt_count=%0d expected 0 0", bus.found_delay, bus.attempt_count);
        end
        n_checks++;
        if (wbus.delay !== WSTART) begin
            n_fail++;
            $display("FAIL reset_wrap_delay: got %h expected %h", wbus.delay, WSTART);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_no_success();
        for (int k = 0; k < 64; k++) begin
            trig_plan[k] = $urandom_range(1, TT);
            succ_plan[k] = 0;
        end
        stray_en = 1'b0;
        run_sweep("no_success", 1'b0);
        n_checks++;
        if (bus.attempt_count !== 32'(4 * TRIES) || bus.found !== 1'b0) begin
            n_fail++;
            $display("FAIL no_success_final: attempt_count=%0d found=%b expected %0d 0", bus.attempt_count, bus.found, 4 * TRIES);
        end
    endtask

    task automatic test_success_third();
        for (int k = 0; k < 64; k++) begin
            trig_plan[k] = $urandom_range(1, TT);
            succ_plan[k] = 0;
        end
        succ_plan[2 * TRIES] = $urandom_range(1, RT);
        run_sweep("success_third", 1'b0);
        n_checks++;
        if (bus.found !== 1'b1 || bus.found_delay !== 32'd4 || bus.attempt_count !== 32'(2 * TRIES)) begin
            n_fail++;
            $display("FAIL success_third_final: found=%b found_delay=%0d attempt_count=%0d expected 1 4 %0d",
                     bus.found, bus.found_delay, bus.attempt_count, 2 * TRIES);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        int n0;
        @(negedge clk); bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.found !== 1'b1 || bus.found_delay !== 32'd4) begin
            n_fail++;
            $display("FAIL abort_keeps_found: busy=%b found=%b found_delay=%0d expected 0 1 4",
                     bus.busy, bus.found, bus.found_delay);
        end
        for (int k = 0; k < 64; k++) begin
            trig_plan[k] = 2;
            succ_plan[k] = 0;
        end
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        while (!bus.success_arm && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus.success_arm !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_wait_res: success_arm=%b after %0d cycles, expected 1", bus.success_arm, n);
        end
        bus.abort = 1'b1;
        #1;
        n_checks++;
        if (bus.success_arm !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_arm_drop: success_arm=%b expected 0", bus.success_arm);
        end
        @(negedge clk); bus.abort = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.success_arm !== 1'b0 || bus.trigger_arm !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b success_arm=%b trigger_arm=%b expected 0 0 0",
                     bus.busy, bus.success_arm, bus.trigger_arm);
        end
        n0 = sd_vals.size();
        repeat (10) @(negedge clk);
        n_checks++;
        if (sd_vals.size() != n0) begin
            n_fail++;
            $display("FAIL abort_stays_idle: set_delay pulses after abort=%0d expected 0", sd_vals.size() - n0);
        end
    endtask

    task automatic test_trig_timeout();
        for (int k = 0; k < 64; k++) begin
            trig_plan[k] = 0;
            succ_plan[k] = $urandom_range(1, RT);
        end
        run_sweep("trig_timeout", 1'b0);
        n_checks++;
        if (arm_len.size() != int'(4 * TRIES) || bus.found !== 1'b0) begin
            n_fail++;
            $display("FAIL trig_timeout_windows: got %0d found=%b expected %0d 0", arm_len.size(), bus.found, 4 * TRIES);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 64; k++) begin
            trig_plan[k] = $urandom_range(1, TT);
            succ_plan[k] = 0;
        end
        trig_plan[0] = TT;
        trig_plan[1] = TT;
        succ_plan[1] = RT;
        run_sweep("simultaneous", 1'b1);
        n_checks++;
        if (bus.found !== 1'b1) begin
            n_fail++;
            $display("FAIL simultaneous_found: got %b expected 1", bus.found);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 64; k++) begin
                trig_plan[k] = $urandom_range(0, TT + 2);
                if ($urandom_range(0, 7) == 0) succ_plan[k] = $urandom_range(1, RT);
                else succ_plan[k] = ($urandom_range(0, 1) == 0) ? 0 : RT + 1;
            end
            stray_en = 1'b1;
            run_sweep($sformatf("random%0d", r), 1'($urandom_range(0, 1)));
        end
        stray_en = 1'b0;
    endtask

    task automatic test_wrap();
        int n = 0;
        for (int k = 0; k < 64; k++) begin
            trig_plan[k] = 0;
            succ_plan[k] = 0;
        end
        model(WSTART, WSTEP, WEND, 3, 3, WTRIES);
        w_sd_cnt = 0;
        w_bad = 0;
        @(negedge clk); wbus.start = 1'b1;
        @(negedge clk); wbus.start = 1'b0;
        while (wbus.busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (wbus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_timeout: busy=%b expected 0", wbus.busy);
        end
        n_checks++;
        if (w_sd_cnt != exp_vals.size() || w_sd_cnt != int'(WTRIES)) begin
            n_fail++;
            $display("FAIL wrap_attempts: set_delay pulses=%0d expected %0d", w_sd_cnt, WTRIES);
        end
        n_checks++;
        if (w_bad != 0 || wbus.delay !== WSTART) begin
            n_fail++;
            $display("FAIL wrap_delay: off-start cycles=%0d final delay=%h expected 0 and %h", w_bad, wbus.delay, WSTART);
        end
        n_checks++;
        if (wbus.attempt_count !== 32'(exp_cnt) || wbus.found !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_result: attempt_count=%0d found=%b expected %0d 0", wbus.attempt_count, wbus.found, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n = 0;
        int n0;
        for (int k = 0; k < 64; k++) begin
            trig_plan[k] = $urandom_range(1, TT);
            succ_plan[k] = 0;
        end
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        while (!bus.target_reset && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus.target_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_reach_reset: target_reset=%b expected 1", bus.target_reset);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.set_delay, bus.target_reset, bus.trigger_arm, bus.success_arm, bus.busy, bus.found} !== 6'b0
            || bus.delay !== DSTART || bus.attempt_count !== 32'd0 || bus.found_delay !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_async_clear: flags=%b delay=%0d attempt_count=%0d found_delay=%0d expected all 0",
                     {bus.set_delay, bus.target_reset, bus.trigger_arm, bus.success_arm, bus.busy, bus.found},
                     bus.delay, bus.attempt_count, bus.found_delay);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n0 = tr_cyc.size();
        repeat (40) @(negedge clk);
        n_checks++;
        if (tr_cyc.size() != n0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_more_pulses: target_reset pulses=%0d busy=%b expected 0 0", tr_cyc.size() - n0, bus.busy);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        wbus.start = 1'b0;
        wbus.abort = 1'b0;
        wbus.trigger = 1'b0;
        wbus.success = 1'b0;
        for (int k = 0; k < 64; k++) begin
            trig_plan[k] = 0;
            succ_plan[k] = 0;
        end
        test_reset();
        test_no_success();
        test_success_third();
        test_abort();
        test_trig_timeout();
        test_simultaneous();
        test_random();
        test_wrap();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
